m_007_bcd_7seg_mux: RTL and testbench

//  Time-multiplexed driver for an N-digit 7-segment display.
//  - Takes a packed BCD word and scans one digit per refresh slot.
//  - Each digit is decoded to segments using the standard 0-9 table; codes 10-15 show a dash.
//  - Options: leading-zero blanking, tear-free updates applied only at frame boundaries, and selectable output polarity.
//  - Sits between numeric datapath logic (counters, timers) and the board display pins.

---
 rtl/m_007_bcd_7seg_mux.sv | 116 +++++++++++
 tb/tb_m_007_bcd_7seg_mux.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/m_007_bcd_7seg_mux.sv
// Scanned BCD to 7-segment driver with tear-free frame-boundary loads and leading-zero blanking.
// Outputs are registered: seg_o/an_o follow the scan index one cycle late; load_i is never stalled.
module m_007_bcd_7seg_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] bcd_i,
   input  logic                    lz_blank_i,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam bit AL = (ACTIVE_LOW != 0);
   localparam logic [6:0] SEG_OFF = AL ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AL}};

   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_active;
   logic [4*NUM_DIGITS-1:0] r_pending;
   logic                    r_pend_vld;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame;

   logic                    w_tc;
   logic                    w_boundary;
   logic [3:0]              w_digit;
   logic [NUM_DIGITS-1:0]   w_an;
   logic                    w_blank;
   logic                    w_zero_run;
   logic [6:0]              w_seg;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'd0:    f_decode = 7'h3F;
         4'd1:    f_decode = 7'h06;
         4'd2:    f_decode = 7'h5B;
         4'd3:    f_decode = 7'h4F;
         4'd4:    f_decode = 7'h66;
         4'd5:    f_decode = 7'h6D;
         4'd6:    f_decode = 7'h7D;
         4'd7:    f_decode = 7'h07;
         4'd8:    f_decode = 7'h7F;
         4'd9:    f_decode = 7'h67;
         default: f_decode = 7'h40;
      endcase
   endfunction

   assign w_tc       = (r_cnt == CNT_LAST);
   assign w_boundary = w_tc && (r_idx == IDX_LAST);

   // Walk from the most significant digit down so w_zero_run means "this digit and all above are 0".
   always_comb begin
      w_digit    = 4'd0;
      w_an       = '0;
      w_blank    = 1'b0;
      w_zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run && (r_active[4*k +: 4] == 4'd0);
         if (IW'(k) == r_idx) begin
            w_digit = r_active[4*k +: 4];
            w_an[k] = 1'b1;
            w_blank = lz_blank_i && (k != 0) && w_zero_run;
         end
      end
      w_seg = w_blank ? 7'h00 : f_decode(w_digit);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_active   <= '0;
         r_pending  <= '0;
         r_pend_vld <= 1'b0;
         r_seg      <= SEG_OFF;
         r_an       <= AN_OFF;
         r_frame    <= 1'b0;
      end else begin
         r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
         if (w_tc)
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         r_frame <= w_boundary;

         // A load landing on the boundary itself goes straight to active.
         if (w_boundary) begin
            if (load_i)
               r_active <= bcd_i;
            else if (r_pend_vld)
               r_active <= r_pending;
            r_pend_vld <= 1'b0;
         end else if (load_i) begin
            r_pending  <= bcd_i;
            r_pend_vld <= 1'b1;
         end

         r_seg <= AL ? ~w_seg : w_seg;
         r_an  <= AL ? ~w_an : w_an;
      end
   end

   assign seg_o   = r_seg;
   assign an_o    = r_an;
   assign frame_o = r_frame;

endmodule

// File: tb/tb_m_007_bcd_7seg_mux.sv
// Bench: 4-digit active-low instance with a short refresh period, plus a 1-digit active-high instance.
module tb_m_007_bcd_7seg_mux;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, load, lz;
   logic [15:0] bcd;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame;

   logic        load1;
   logic [3:0]  bcd1;
   logic [6:0]  seg1;
   logic [0:0]  an1;
   logic        frame1;

   int total = 0;
   int bad   = 0;

   m_007_bcd_7seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u_dut (
      .clk_i(clk), .rst_i(rst), .load_i(load), .bcd_i(bcd), .lz_blank_i(lz),
      .seg_o(seg), .an_o(an), .frame_o(frame)
   );

   m_007_bcd_7seg_mux #(.NUM_DIGITS(1), .REFRESH_DIV(3), .ACTIVE_LOW(0)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .load_i(load1), .bcd_i(bcd1), .lz_blank_i(lz),
      .seg_o(seg1), .an_o(an1), .frame_o(frame1)
   );

   typedef struct {
      logic            lz;
      int              la;
      logic [15:0]     va;
      int              lb;
      logic [15:0]     vb;
      logic [3:0][6:0] exp;   // {digit3, digit2, digit1, digit0}, active-low
   } frame_t;

   frame_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One 16-cycle frame starting just after a boundary (or reset release).
   task automatic run_frame(input frame_t f, input string tag);
      int d;
      logic [3:0] e_an;
      lz = f.lz;
      for (int s = 1; s <= 16; s++) begin
         load = (s == f.la) || (s == f.lb);
         bcd  = (s == f.lb) ? f.vb : f.va;
         step;
         load = 1'b0;
         d    = (s - 1) / 4;
         e_an = ~(4'b0001 << d);
         chk({tag, " an"}, 32'(an), 32'(e_an));
         chk({tag, " seg"}, 32'(seg), 32'(f.exp[d]));
         chk({tag, " frame"}, 32'(frame), (s == 16) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic wait_frame1;
      int n;
      n = 0;
      while (!frame1 && n < 10) begin
         step;
         n++;
      end
      chk("u1 frame timeout", 32'(frame1), 32'd1);
   endtask

   frame_t zf;
   int     n;

   initial begin
      rst = 1'b1; load = 1'b0; lz = 1'b0; bcd = 16'h0;
      load1 = 1'b0; bcd1 = 4'h0;

      tbl[0] = '{1'b0, 5,  16'h1234, 0,  16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};
      tbl[1] = '{1'b0, 3,  16'h1111, 10, 16'h9999, {7'h79, 7'h24, 7'h30, 7'h19}};
      tbl[2] = '{1'b1, 4,  16'h5555, 16, 16'h00A0, {7'h18, 7'h18, 7'h18, 7'h18}};
      tbl[3] = '{1'b1, 0,  16'h0000, 0,  16'h0000, {7'h7F, 7'h7F, 7'h3F, 7'h40}};
      tbl[4] = '{1'b0, 7,  16'h0100, 0,  16'h0000, {7'h40, 7'h40, 7'h3F, 7'h40}};
      tbl[5] = '{1'b1, 12, 16'h8765, 0,  16'h0000, {7'h7F, 7'h79, 7'h40, 7'h40}};
      tbl[6] = '{1'b0, 1,  16'hFBC0, 0,  16'h0000, {7'h00, 7'h78, 7'h02, 7'h12}};
      tbl[7] = '{1'b1, 0,  16'h0000, 0,  16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h40}};
      zf     = '{1'b0, 0,  16'h0000, 0,  16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};

      step;
      step;
      chk("reset seg", 32'(seg), 32'h7F);
      chk("reset an", 32'(an), 32'hF);
      chk("reset frame", 32'(frame), 32'd0);
      chk("u1 reset seg", 32'(seg1), 32'h00);
      chk("u1 reset an", 32'(an1), 32'h0);
      chk("u1 reset frame", 32'(frame1), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_frame(tbl[i], $sformatf("frame%0d", i));

      // Reset while digit 2 is scanned with a load pending: the pending value must vanish.
      lz = 1'b0;
      for (int s = 1; s <= 9; s++) begin
         load = (s == 2);
         bcd  = 16'h7777;
         step;
         load = 1'b0;
      end
      chk("pre-reset an", 32'(an), 32'hB);
      rst = 1'b1;
      step;
      chk("midscan reset seg", 32'(seg), 32'h7F);
      chk("midscan reset an", 32'(an), 32'hF);
      chk("midscan reset frame", 32'(frame), 32'd0);
      step;
      rst = 1'b0;
      run_frame(zf, "post-reset0");
      run_frame(zf, "post-reset1");

      // Single-digit active-high instance.
      step;
      chk("u1 idle an", 32'(an1), 32'h1);
      chk("u1 idle seg", 32'(seg1), 32'h3F);
      wait_frame1;
      n = 0;
      do begin
         step;
         n++;
      end while (!frame1 && n < 10);
      chk("u1 frame period", 32'(n), 32'd3);
      bcd1  = 4'h8;
      load1 = 1'b1;
      step;
      load1 = 1'b0;
      chk("u1 no early update", 32'(seg1), 32'h3F);
      wait_frame1;
      step;
      chk("u1 digit8 seg", 32'(seg1), 32'h7F);
      chk("u1 digit8 an", 32'(an1), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
